// File: rtl/dds_pkg.sv
// Shared definitions for the DDS tuning-word loader.
// Contents: frame command encodings, loader FSM state codes and the default
// tuning-word width.
package dds_pkg;

    // Default tuning-word width, matching the DDS `tune` slice on the pins
    localparam int DEFAULT_TW_W = 14;

    // Command field encodings; the command field is the first two frame bits
    localparam logic [1:0] CMD_NOP       = 2'b00;
    localparam logic [1:0] CMD_WR        = 2'b01;
    localparam logic [1:0] CMD_COMMIT    = 2'b10;
    localparam logic [1:0] CMD_WR_COMMIT = 2'b11;

    // Loader FSM state codes
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/dds_tw_loader_if.sv
// Serial pin bundle between the host and the tuning-word loader.
//   sclk_in : serial clock from the host (asynchronous to the DDS clock)
//   cs_n_in : active-low frame select from the host
//   sdi_in  : serial data from the host, MSB first
//   sdo     : serial readback data to the host
//   sdo_oe  : output enable for sdo; high while a frame is active
// The master modport is the host side and the slave modport is the loader.
interface dds_tw_loader_if;

    logic sclk_in;
    logic cs_n_in;
    logic sdi_in;
    logic sdo;
    logic sdo_oe;

    modport master (
        output sclk_in,
        output cs_n_in,
        output sdi_in,
        input  sdo,
        input  sdo_oe
    );

    modport slave (
        input  sclk_in,
        input  cs_n_in,
        input  sdi_in,
        output sdo,
        output sdo_oe
    );

endinterface

// File: rtl/dds_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, followed by one extra
// register used for edge detection.
//   clk   : destination clock
//   rst   : synchronous, active-high reset; forces the chain to RESET_VAL
//   d     : asynchronous input
//   q     : synchronised level
//   rise  : one-clk pulse on a synchronised 0->1 transition
//   fall  : one-clk pulse on a synchronised 1->0 transition
module dds_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchroniser chain plus the delayed copy used for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{RESET_VAL}};
            prev_r <= RESET_VAL;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
            prev_r <= sync_r[STAGES-1];
        end
    end

    // Edge pulses are decoded only from registered values, so they are glitch free
    assign q    = sync_r[STAGES-1];
    assign rise = sync_r[STAGES-1] & ~prev_r;
    assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/dds_tw_loader.sv
// Serial programming front-end for the DDS tuning word.
// A host clocks CMD_W+TW_W bit frames (command first, MSB first) over the
// pin bundle. The loader holds a staged and an active tuning word and shifts
// the active word back out on sdo during every frame.
//   clk         : DDS system clock
//   rst         : synchronous, active-high reset
//   bus         : serial pin bundle (sclk_in, cs_n_in, sdi_in in; sdo, sdo_oe out)
//   tuning_word : active tuning word to the DDS core
//   tw_update   : one-clk pulse in the cycle a newly committed tuning_word appears
//   frame_err   : one-clk pulse when a frame ends with the wrong bit count
//   busy        : high from frame start until end-of-frame processing completes
module dds_tw_loader
    import dds_pkg::*;
#(
    parameter int               TW_W        = DEFAULT_TW_W,
    parameter int               CMD_W       = 2,
    parameter logic [TW_W-1:0]  RESET_TW    = {TW_W{1'b0}},
    parameter int               SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    dds_tw_loader_if.slave      bus,
    output logic [TW_W-1:0]     tuning_word,
    output logic                tw_update,
    output logic                frame_err,
    output logic                busy
);

    localparam int FRAME_W = CMD_W + TW_W;
    localparam int CNT_MAX = FRAME_W + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CMD_CNT   = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] SAT_CNT   = CNT_W'(CNT_MAX);

    // Synchronised pin levels and edges
    logic       sclk_rise_s;
    logic       sclk_fall_s;
    logic       cs_rise_s;
    logic       cs_fall_s;
    logic       sdi_s;
    logic       sclk_lvl_unused_s;
    logic       cs_lvl_unused_s;
    logic [1:0] sdi_edge_unused_s;

    // Registered state
    state_t             state_r;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic [FRAME_W-1:0] frame_r;
    logic [TW_W-1:0]    rb_r;
    logic [TW_W-1:0]    staged_r;
    logic [TW_W-1:0]    tw_r;
    logic               tw_upd_r;
    logic               ferr_r;
    logic               busy_r;
    logic               sdo_r;

    // Next-state values
    state_t             state_nx_s;
    logic [CNT_W-1:0]   bit_cnt_nx_s;
    logic [FRAME_W-1:0] frame_nx_s;
    logic [TW_W-1:0]    rb_nx_s;
    logic [TW_W-1:0]    staged_nx_s;
    logic [TW_W-1:0]    tw_nx_s;
    logic               tw_upd_nx_s;
    logic               ferr_nx_s;
    logic               busy_nx_s;
    logic               sdo_nx_s;

    logic [1:0]         cmd_s;
    logic [TW_W-1:0]    data_s;

    // Idle levels: sclk low, cs_n high, so reset never fabricates an edge
    dds_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.sclk_in),
        .q    (sclk_lvl_unused_s),
        .rise (sclk_rise_s),
        .fall (sclk_fall_s)
    );

    dds_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.cs_n_in),
        .q    (cs_lvl_unused_s),
        .rise (cs_rise_s),
        .fall (cs_fall_s)
    );

    // sdi shares the sclk sync depth so it stays aligned with the sampling edge
    dds_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.sdi_in),
        .q    (sdi_s),
        .rise (sdi_edge_unused_s[0]),
        .fall (sdi_edge_unused_s[1])
    );

    assign cmd_s  = frame_r[FRAME_W-1 -: 2];
    assign data_s = frame_r[TW_W-1:0];

    // Frame FSM: IDLE -> SHIFT -> DONE -> IDLE, plus staged/active word updates
    always_comb begin
        state_nx_s   = state_r;
        bit_cnt_nx_s = bit_cnt_r;
        frame_nx_s   = frame_r;
        rb_nx_s      = rb_r;
        staged_nx_s  = staged_r;
        tw_nx_s      = tw_r;
        tw_upd_nx_s  = 1'b0;
        ferr_nx_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // sclk edges are never acted on here, including one that
                // coincides with the cs_n fall
                if (cs_fall_s) begin
                    state_nx_s   = ST_SHIFT;
                    bit_cnt_nx_s = CNT_ZERO;
                    rb_nx_s      = tw_r;
                end else begin
                    state_nx_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    state_nx_s = ST_DONE;
                end else if (sclk_rise_s) begin
                    // Keep the first FRAME_W bits; the counter runs one past
                    // the frame length so over-length frames are still caught
                    if (bit_cnt_r < FRAME_CNT) begin
                        frame_nx_s = {frame_r[FRAME_W-2:0], sdi_s};
                    end else begin
                        frame_nx_s = frame_r;
                    end
                    if (bit_cnt_r < SAT_CNT) begin
                        bit_cnt_nx_s = bit_cnt_r + CNT_ONE;
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r;
                    end
                end else if (sclk_fall_s && (bit_cnt_r > CMD_CNT)) begin
                    // Readback advances only after the host has sampled the MSB
                    rb_nx_s = {rb_r[TW_W-2:0], 1'b0};
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
                if (bit_cnt_r == FRAME_CNT) begin
                    case (cmd_s)
                        CMD_WR: begin
                            staged_nx_s = data_s;
                        end
                        CMD_COMMIT: begin
                            tw_nx_s     = staged_r;
                            tw_upd_nx_s = 1'b1;
                        end
                        CMD_WR_COMMIT: begin
                            staged_nx_s = data_s;
                            tw_nx_s     = data_s;
                            tw_upd_nx_s = 1'b1;
                        end
                        default: begin
                            tw_upd_nx_s = 1'b0;
                        end
                    endcase
                end else begin
                    ferr_nx_s = 1'b1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output values are computed from next state so the pins come straight from flops
    assign busy_nx_s = (state_nx_s != ST_IDLE);
    assign sdo_nx_s  = ((state_nx_s == ST_SHIFT) && (bit_cnt_nx_s >= CMD_CNT)) ?
                       rb_nx_s[TW_W-1] : 1'b0;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= CNT_ZERO;
            frame_r   <= {FRAME_W{1'b0}};
            rb_r      <= {TW_W{1'b0}};
            staged_r  <= RESET_TW;
            tw_r      <= RESET_TW;
            tw_upd_r  <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
            sdo_r     <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            bit_cnt_r <= bit_cnt_nx_s;
            frame_r   <= frame_nx_s;
            rb_r      <= rb_nx_s;
            staged_r  <= staged_nx_s;
            tw_r      <= tw_nx_s;
            tw_upd_r  <= tw_upd_nx_s;
            ferr_r    <= ferr_nx_s;
            busy_r    <= busy_nx_s;
            sdo_r     <= sdo_nx_s;
        end
    end

    assign tuning_word = tw_r;
    assign tw_update   = tw_upd_r;
    assign frame_err   = ferr_r;
    assign busy        = busy_r;
    assign bus.sdo     = sdo_r;
    assign bus.sdo_oe  = busy_r;

endmodule

// File: tb/tb_dds_tw_loader.sv
// Directed bench for dds_tw_loader: host frames at sclk = clk/8, expected
// values hand-computed per frame.
module tb_dds_tw_loader;

    localparam int TW_W = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic [TW_W-1:0]   tuning_word;
    logic              tw_update;
    logic              frame_err;
    logic              busy;

    dds_tw_loader_if bus ();

    dds_tw_loader #(
        .TW_W        (TW_W),
        .CMD_W       (2),
        .RESET_TW    (14'h0000),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .tuning_word (tuning_word),
        .tw_update   (tw_update),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt  = 0;
    int err_cnt  = 0;
    logic [TW_W-1:0] model_tw;
    logic [15:0]     rb_cap;

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (tw_update === 1'b1) upd_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input string tag);
        @(negedge clk);
        bus.cs_n_in = 1'b0;
        rb_cap = 16'h0000;
        wait_clks(4);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_sdo_oe"}, {31'd0, bus.sdo_oe}, 32'd1);
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.sdi_in = bits[i];
            wait_clks(4);
            rb_cap = {rb_cap[14:0], bus.sdo};
            bus.sclk_in = 1'b1;
            wait_clks(4);
            bus.sclk_in = 1'b0;
        end
    endtask

    task automatic close_frame(input string tag, input logic [TW_W-1:0] exp_tw,
                               input logic exp_upd, input logic exp_err);
        int u0;
        int e0;
        wait_clks(4);
        bus.cs_n_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        u0 = upd_cnt;
        e0 = err_cnt;
        chk({tag, "_pre_tw"}, {18'd0, tuning_word}, {18'd0, model_tw});
        chk({tag, "_pre_busy"}, {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_tw"}, {18'd0, tuning_word}, {18'd0, exp_tw});
        chk({tag, "_upd"}, {31'd0, tw_update}, {31'd0, exp_upd});
        chk({tag, "_err"}, {31'd0, frame_err}, {31'd0, exp_err});
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_oe_end"}, {31'd0, bus.sdo_oe}, 32'd0);
        wait_clks(4);
        #1;
        chk({tag, "_upd_pulses"}, upd_cnt - u0, {31'd0, exp_upd});
        chk({tag, "_err_pulses"}, err_cnt - e0, {31'd0, exp_err});
        model_tw = exp_tw;
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0;
        int e0;
        rst = 1'b1;
        bus.cs_n_in = 1'b1;
        bus.sclk_in = 1'b0;
        bus.sdi_in  = 1'b0;
        model_tw = 14'h0000;
        rb_cap = 16'h0000;
        wait_clks(2);
        chk("rst_sdo", {31'd0, bus.sdo}, 32'd0);
        rst = 1'b0;
        wait_clks(2);
        chk("rst_tw", {18'd0, tuning_word}, 32'h0000);
        chk("rst_oe", {31'd0, bus.sdo_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_upd", {31'd0, tw_update}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        chk("rst_pulses", upd_cnt + err_cnt, 32'd0);

        // 11 + 0x1234: write and commit
        start_frame("wrc");
        shift_bits(32'h0000_D234, 16);
        chk("wrc_rb", {16'd0, rb_cap}, 32'h0000);
        close_frame("wrc", 14'h1234, 1'b1, 1'b0);

        // 01 + 0x0ABC: staged only
        start_frame("wr");
        shift_bits(32'h0000_4ABC, 16);
        chk("wr_rb", {16'd0, rb_cap}, 32'h1234);
        close_frame("wr", 14'h1234, 1'b0, 1'b0);

        // 10 + 0x3FFF: commit, data bits ignored
        start_frame("cmt");
        shift_bits(32'h0000_BFFF, 16);
        chk("cmt_rb", {16'd0, rb_cap}, 32'h1234);
        close_frame("cmt", 14'h0ABC, 1'b1, 1'b0);

        // 00 + 0x2A5A: NOP readback of active word
        start_frame("nop");
        shift_bits(32'h0000_2A5A, 16);
        chk("nop_rb", {16'd0, rb_cap}, 32'h0ABC);
        close_frame("nop", 14'h0ABC, 1'b0, 1'b0);

        // sclk toggling with cs_n high is ignored
        u0 = upd_cnt;
        e0 = err_cnt;
        for (int k = 0; k < 3; k++) begin
            bus.sclk_in = 1'b1;
            wait_clks(4);
            bus.sclk_in = 1'b0;
            wait_clks(4);
        end
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_oe", {31'd0, bus.sdo_oe}, 32'd0);
        chk("idle_pulses", (upd_cnt - u0) + (err_cnt - e0), 32'd0);
        chk("idle_tw", {18'd0, tuning_word}, 32'h0ABC);

        // 10-bit frame of cmd 11
        start_frame("short");
        shift_bits(32'h0000_0355, 10);
        close_frame("short", 14'h0ABC, 1'b0, 1'b1);

        // 18-bit frame; readback runs out to zeros after the last word bit
        start_frame("long");
        shift_bits(32'h0003_888A, 18);
        chk("long_rb", {16'd0, rb_cap}, 32'h2AF0);
        close_frame("long", 14'h0ABC, 1'b0, 1'b1);

        // cs_n pulse with no sclk
        start_frame("empty");
        close_frame("empty", 14'h0ABC, 1'b0, 1'b1);

        // cs_n fall coincident with an sclk rise: that edge is not counted
        @(negedge clk);
        bus.cs_n_in = 1'b0;
        bus.sclk_in = 1'b1;
        rb_cap = 16'h0000;
        wait_clks(4);
        bus.sclk_in = 1'b0;
        wait_clks(4);
        chk("coin_busy", {31'd0, busy}, 32'd1);
        shift_bits(32'h0000_D555, 16);
        chk("coin_rb", {16'd0, rb_cap}, 32'h0ABC);
        close_frame("coin", 14'h1555, 1'b1, 1'b0);

        // Reset after 8 bits of 11 + 0x3C3C
        start_frame("rstmid");
        shift_bits(32'h0000_00FC, 8);
        @(negedge clk);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        chk("rstmid_tw", {18'd0, tuning_word}, 32'h0000);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        model_tw = 14'h0000;
        shift_bits(32'h0000_003C, 8);
        close_frame("rstmid", 14'h0000, 1'b0, 1'b1);

        // Clean frame 11 + 0x0001 afterwards
        start_frame("post");
        shift_bits(32'h0000_C001, 16);
        chk("post_rb", {16'd0, rb_cap}, 32'h0000);
        close_frame("post", 14'h0001, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
